// File: rtl/interval_capture_if.sv
// rtl/interval_capture_if.sv - event inputs and capture outputs of interval_capture
interface interval_capture_if #(
  parameter int bitwidth = 8
) ();
  logic                start;
  logic                stop;
  logic                abort;
  logic [bitwidth-1:0] measured_value;
  logic                valid;
  logic                overflow;
  logic                busy;

  modport master (
    output start, stop, abort,
    input  measured_value, valid, overflow, busy
  );

  modport slave (
    input  start, stop, abort,
    output measured_value, valid, overflow, busy
  );
endinterface

// File: rtl/interval_capture.sv
// rtl/interval_capture.sv - measures start/stop (or start/start) intervals in clock cycles
module interval_capture #(
  parameter int bitwidth       = 8,
  parameter bit measure_period = 1'b0
) (
  input logic             clock,
  input logic             reset,
  interval_capture_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, MEASURING = 1'b1} state_t;

  localparam logic [bitwidth-1:0] count_max = '1;
  localparam logic [bitwidth-1:0] count_one = {{(bitwidth-1){1'b0}}, 1'b1};

  state_t              state_q, state_d;
  logic [bitwidth-1:0] count_q, count_d;
  logic [bitwidth-1:0] value_q, value_d;
  logic                sat_q, sat_d;
  logic                ovf_q, ovf_d;
  logic                valid_q, valid_d;
  logic                start_prev_q, start_prev_d;
  logic                stop_prev_q, stop_prev_d;
  logic                start_evt, stop_evt;

  assign start_evt = bus.start & ~start_prev_q;
  assign stop_evt  = bus.stop & ~stop_prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      value_q      <= '0;
      sat_q        <= 1'b0;
      ovf_q        <= 1'b0;
      valid_q      <= 1'b0;
      start_prev_q <= 1'b0;
      stop_prev_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      value_q      <= value_d;
      sat_q        <= sat_d;
      ovf_q        <= ovf_d;
      valid_q      <= valid_d;
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
    end
  end

  // A stop event while measuring ends the run in both modes: capture in
  // one-shot mode, cancellation in period mode.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (!bus.abort && start_evt) state_d = MEASURING;
      MEASURING: if (bus.abort || stop_evt)   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d      = count_q;
    sat_d        = sat_q;
    value_d      = value_q;
    ovf_d        = ovf_q;
    valid_d      = 1'b0;
    start_prev_d = bus.start;
    stop_prev_d  = bus.stop;
    if (bus.abort) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (state_q == IDLE) begin
      if (start_evt) begin
        count_d = count_one;
        sat_d   = 1'b0;
      end
    end else if ((!measure_period && stop_evt) || (measure_period && !stop_evt && start_evt)) begin
      value_d = count_q;
      ovf_d   = sat_q;
      valid_d = 1'b1;
      count_d = measure_period ? count_one : '0;
      sat_d   = 1'b0;
    end else if (stop_evt) begin
      count_d = '0;
      sat_d   = 1'b0;
    end else if (count_q != count_max) begin
      count_d = count_q + count_one;
      sat_d   = sat_q | ((count_q + count_one) == count_max);
    end else begin
      sat_d = 1'b1;
    end
  end

  always_comb begin
    bus.measured_value = value_q;
    bus.overflow       = ovf_q;
    bus.valid          = valid_q;
    bus.busy           = (state_q == MEASURING);
  end
endmodule

// File: tb/tb_interval_capture.sv
// tb/tb_interval_capture.sv - randomized self-checking bench for interval_capture
module tb_interval_capture;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  interval_capture_if #(.bitwidth(8)) if_os8 ();
  interval_capture_if #(.bitwidth(4)) if_os4 ();
  interval_capture_if #(.bitwidth(8)) if_per ();

  interval_capture #(.bitwidth(8), .measure_period(1'b0)) dut_os8 (.clock(clock), .reset(reset), .bus(if_os8));
  interval_capture #(.bitwidth(4), .measure_period(1'b0)) dut_os4 (.clock(clock), .reset(reset), .bus(if_os4));
  interval_capture #(.bitwidth(8), .measure_period(1'b1)) dut_per (.clock(clock), .reset(reset), .bus(if_per));

  int vectors = 0;
  int miscompares = 0;
  // model of the last reported capture per DUT: 0 = os8, 1 = os4, 2 = period
  int exp_val [3];
  bit exp_ovf [3];

  task automatic drive(input int w, input bit s, input bit p, input bit a);
    case (w)
      0: begin if_os8.start = s; if_os8.stop = p; if_os8.abort = a; end
      1: begin if_os4.start = s; if_os4.stop = p; if_os4.abort = a; end
      default: begin if_per.start = s; if_per.stop = p; if_per.abort = a; end
    endcase
  endtask

  task automatic sample(input int w, output int val, output bit v, output bit o, output bit b);
    case (w)
      0: begin val = int'(if_os8.measured_value); v = if_os8.valid; o = if_os8.overflow; b = if_os8.busy; end
      1: begin val = int'(if_os4.measured_value); v = if_os4.valid; o = if_os4.overflow; b = if_os4.busy; end
      default: begin val = int'(if_per.measured_value); v = if_per.valid; o = if_per.overflow; b = if_per.busy; end
    endcase
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Start rises at relative edge 0, stop rises at edge n; expected result is
  // n clipped to the counter maximum, overflow once the maximum is reached.
  task automatic run_oneshot(input int w, input int n, input int start_hold, input int stop_hold,
                             input int restart_at, input bit stop_at0, input string tag);
    int mx, val, expv;
    bit v, o, b, expo, s, p;
    mx = (w == 1) ? 15 : 255;
    expv = (n > mx) ? mx : n;
    expo = (n >= mx);
    drive(w, 0, 0, 0);
    step();
    for (int i = 0; i <= n + stop_hold + 1; i++) begin
      s = (i < start_hold) || (i == restart_at);
      p = ((i >= n) && (i < n + stop_hold)) || (stop_at0 && i == 0);
      drive(w, s, p, 0);
      step();
      sample(w, val, v, o, b);
      if (i == n) begin
        exp_val[w] = expv;
        exp_ovf[w] = expo;
      end
      vectors++;
      if (b !== (i < n)) begin
        miscompares++;
        $display("FAIL %s busy edge %0d: got %0b want %0b", tag, i, b, (i < n));
      end
      vectors++;
      if (v !== (i == n)) begin
        miscompares++;
        $display("FAIL %s valid edge %0d: got %0b want %0b", tag, i, v, (i == n));
      end
      vectors++;
      if (val !== exp_val[w] || o !== exp_ovf[w]) begin
        miscompares++;
        $display("FAIL %s value edge %0d: got %0d/ovf %0b want %0d/ovf %0b", tag, i, val, o, exp_val[w], exp_ovf[w]);
      end
    end
    drive(w, 0, 0, 0);
    step();
  endtask

  task automatic check_all_clear(input string tag);
    int val;
    bit v, o, b;
    for (int w = 0; w < 3; w++) begin
      sample(w, val, v, o, b);
      vectors++;
      if (val !== 0 || v !== 1'b0 || o !== 1'b0 || b !== 1'b0) begin
        miscompares++;
        $display("FAIL %s dut%0d: got val %0d valid %0b ovf %0b busy %0b want all 0", tag, w, val, v, o, b);
      end
    end
  endtask

  task automatic test_reset();
    for (int w = 0; w < 3; w++) drive(w, 0, 0, 0);
    #12;
    check_all_clear("reset_state");
    step();
    reset = 1'b1;
    step();
    check_all_clear("after_release");
    for (int w = 0; w < 3; w++) begin
      exp_val[w] = 0;
      exp_ovf[w] = 0;
    end
  endtask

  task automatic test_oneshot_basic();
    run_oneshot(0, 12, 1, 1, -1, 0, "basic12");
    run_oneshot(0, 12, 6, 3, -1, 0, "held12");
  endtask

  task automatic test_overflow();
    run_oneshot(1, 20, 1, 1, -1, 0, "sat20");
    run_oneshot(1, 5, 1, 1, -1, 0, "after_sat5");
    run_oneshot(0, 300, 2, 1, -1, 0, "sat300");
    run_oneshot(0, 9, 1, 2, -1, 0, "after_sat9");
  endtask

  task automatic test_random_oneshot();
    int n, sh, ph, ra, w;
    for (int k = 0; k < 10; k++) begin
      w  = k % 2;
      n  = (w == 1) ? $urandom_range(1, 30) : $urandom_range(1, 280);
      sh = $urandom_range(1, n);
      ph = $urandom_range(1, 4);
      ra = -1;
      if (sh < n && $urandom_range(0, 1) == 1) ra = $urandom_range(sh + 1, n);
      run_oneshot(w, n, sh, ph, ra, 0, "rand_oneshot");
    end
  endtask

  task automatic test_coincident();
    run_oneshot(0, 2 + $urandom_range(0, 20), 1, 1, -1, 1, "idle_start_stop");
  endtask

  task automatic test_period();
    int periods[$];
    int pulses[$];
    int last, val, k;
    bit v, o, b, is_pulse, want_v;
    for (int j = 0; j < 3; j++) periods.push_back(12);
    for (int j = 0; j < 5; j++) periods.push_back($urandom_range(2, 40));
    pulses.push_back(0);
    foreach (periods[j]) pulses.push_back(pulses[j] + periods[j]);
    last = pulses[pulses.size() - 1];
    drive(2, 0, 0, 0);
    step();
    k = 0;
    for (int i = 0; i <= last + 2; i++) begin
      is_pulse = (k < pulses.size()) && (pulses[k] == i);
      drive(2, is_pulse, 0, 0);
      step();
      sample(2, val, v, o, b);
      want_v = is_pulse && (k > 0);
      if (want_v) begin
        exp_val[2] = periods[k - 1];
        exp_ovf[2] = 0;
      end
      if (is_pulse) k++;
      vectors++;
      if (b !== 1'b1) begin
        miscompares++;
        $display("FAIL period busy edge %0d: got %0b want 1", i, b);
      end
      vectors++;
      if (v !== want_v) begin
        miscompares++;
        $display("FAIL period valid edge %0d: got %0b want %0b", i, v, want_v);
      end
      vectors++;
      if (val !== exp_val[2] || o !== exp_ovf[2]) begin
        miscompares++;
        $display("FAIL period value edge %0d: got %0d/ovf %0b want %0d/ovf %0b", i, val, o, exp_val[2], exp_ovf[2]);
      end
    end
    // a stop event cancels the running period without reporting it
    drive(2, 0, 1, 0);
    step();
    sample(2, val, v, o, b);
    vectors++;
    if (b !== 1'b0 || v !== 1'b0 || val !== exp_val[2]) begin
      miscompares++;
      $display("FAIL period_stop: got busy %0b valid %0b val %0d want 0 0 %0d", b, v, val, exp_val[2]);
    end
    drive(2, 0, 0, 0);
    step();
  endtask

  task automatic test_abort();
    int val;
    bit v, o, b, s, p, a;
    drive(0, 0, 0, 0);
    step();
    for (int i = 0; i <= 13; i++) begin
      s = (i == 0);
      a = (i == 5);
      p = (i == 12);
      drive(0, s, p, a);
      step();
      sample(0, val, v, o, b);
      vectors++;
      if (b !== (i < 5) || v !== 1'b0) begin
        miscompares++;
        $display("FAIL abort edge %0d: got busy %0b valid %0b want %0b 0", i, b, v, (i < 5));
      end
      vectors++;
      if (val !== exp_val[0] || o !== exp_ovf[0]) begin
        miscompares++;
        $display("FAIL abort value edge %0d: got %0d want %0d", i, val, exp_val[0]);
      end
    end
    drive(0, 0, 0, 0);
    step();
    drive(0, 1, 0, 1);
    step();
    sample(0, val, v, o, b);
    vectors++;
    if (b !== 1'b0 || v !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_over_start: got busy %0b valid %0b want 0 0", b, v);
    end
    drive(0, 0, 0, 0);
    step();
  endtask

  task automatic test_reset_mid();
    int val;
    bit v, o, b;
    drive(0, 0, 0, 0);
    step();
    for (int i = 0; i < 4; i++) begin
      drive(0, (i == 0), 0, 0);
      step();
    end
    sample(0, val, v, o, b);
    vectors++;
    if (b !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid pre busy: got %0b want 1", b);
    end
    #2 reset = 1'b0;
    #1 check_all_clear("reset_async");
    step();
    drive(0, 0, 1, 0);
    step();
    check_all_clear("reset_held");
    for (int w = 0; w < 3; w++) begin
      exp_val[w] = 0;
      exp_ovf[w] = 0;
    end
    drive(0, 1, 0, 0);
    reset = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      drive(0, 1, (i == 7), 0);
      step();
      sample(0, val, v, o, b);
      if (i == 7) exp_val[0] = 7;
      vectors++;
      if (b !== (i < 7) || v !== (i == 7) || val !== exp_val[0] || o !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_restart edge %0d: got busy %0b valid %0b val %0d want %0b %0b %0d",
                 i, b, v, val, (i < 7), (i == 7), exp_val[0]);
      end
    end
    drive(0, 0, 0, 0);
    step();
  endtask

  initial begin
    test_reset();
    test_oneshot_basic();
    test_overflow();
    test_random_oneshot();
    test_coincident();
    test_period();
    test_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
